// File: rtl/gpio_pwm_if.sv
// Bundle of the GPIO-state word, run/stop control and PWM pin outputs
// exchanged between the GPIO register bank (master) and the PWM bank (slave).
interface gpio_pwm_if #(
    parameter int CHANNELS = 4,
    parameter int DUTY_W   = 8
);
    logic [CHANNELS*DUTY_W-1:0] i_gpio_state;
    logic                       i_enable;
    logic [CHANNELS-1:0]        o_pwm;
    logic                       o_period_start;

    modport master (
        output i_gpio_state,
        output i_enable,
        input  o_pwm,
        input  o_period_start
    );

    modport slave (
        input  i_gpio_state,
        input  i_enable,
        output o_pwm,
        output o_period_start
    );
endinterface

// File: rtl/gpio_pwm_bank.sv
// PWM bank driven by packed duty fields from the GPIO state word; duties are
// double-buffered and only reloaded at a period wrap so outputs never glitch.
module gpio_pwm_bank #(
    parameter int CHANNELS = 4,
    parameter int DUTY_W   = 8,
    parameter int PRESCALE = 1
) (
    input  logic        clk,
    input  logic        areset,
    gpio_pwm_if.slave   bus
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]     PRESC_LAST = PW'(PRESCALE - 1);
    // A period is MAX steps, so the count tops out at MAX-1 (all ones but the LSB).
    localparam logic [DUTY_W-1:0] CNT_LAST   = {{(DUTY_W-1){1'b1}}, 1'b0};

    logic [PW-1:0]       presc;
    logic [DUTY_W-1:0]   cnt;
    logic [DUTY_W-1:0]   shadow [CHANNELS];
    logic [CHANNELS-1:0] pwm_q;
    logic                period_start_q;
    logic                tick;
    logic                wrap;

    assign tick = bus.i_enable && (presc == PRESC_LAST);
    assign wrap = tick && (cnt == CNT_LAST);

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            presc          <= '0;
            cnt            <= '0;
            pwm_q          <= '0;
            period_start_q <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) shadow[i] <= '0;
        end else if (!bus.i_enable) begin
            // Stopped: track the input continuously so a restart uses fresh duties.
            presc          <= '0;
            cnt            <= '0;
            pwm_q          <= '0;
            period_start_q <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) shadow[i] <= bus.i_gpio_state[i*DUTY_W +: DUTY_W];
        end else begin
            presc <= tick ? '0 : presc + PW'(1);
            if (tick) cnt <= wrap ? '0 : cnt + DUTY_W'(1);
            for (int i = 0; i < CHANNELS; i++) begin
                if (wrap) shadow[i] <= bus.i_gpio_state[i*DUTY_W +: DUTY_W];
                pwm_q[i] <= (cnt < shadow[i]);
            end
            period_start_q <= wrap;
        end
    end

    assign bus.o_pwm          = pwm_q;
    assign bus.o_period_start = period_start_q;
endmodule

// File: tb/tb_gpio_pwm_bank.sv
// Bench for gpio_pwm_bank: three instances (prescale 1 and 3 with 4-bit duties,
// defaults with 8-bit duties) checked against an arithmetic period model.
module tb_gpio_pwm_bank;
    localparam int P_M   [3] = '{1, 3, 1};
    localparam int MAX_M [3] = '{15, 15, 255};
    localparam int DW_M  [3] = '{4, 4, 8};

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    gpio_pwm_if #(.CHANNELS(4), .DUTY_W(4)) bus_a ();
    gpio_pwm_if #(.CHANNELS(4), .DUTY_W(4)) bus_b ();
    gpio_pwm_if #(.CHANNELS(4), .DUTY_W(8)) bus_c ();

    gpio_pwm_bank #(.CHANNELS(4), .DUTY_W(4), .PRESCALE(1)) dut_a (.clk(clk), .areset(rst), .bus(bus_a));
    gpio_pwm_bank #(.CHANNELS(4), .DUTY_W(4), .PRESCALE(3)) dut_b (.clk(clk), .areset(rst), .bus(bus_b));
    gpio_pwm_bank #(.CHANNELS(4), .DUTY_W(8), .PRESCALE(1)) dut_c (.clk(clk), .areset(rst), .bus(bus_c));

    // clock / reset
    always #5 clk = ~clk;

    // ---------------- model ----------------
    int         n_m     [3]    = '{0, 0, 0};
    int         duty_m  [3][4] = '{default: 0};
    logic [3:0] exp_pwm [3]    = '{default: '0};
    logic       exp_ps  [3]    = '{default: 1'b0};

    function automatic logic [31:0] in_gpio(int k);
        case (k)
            0:       return 32'(bus_a.i_gpio_state);
            1:       return 32'(bus_b.i_gpio_state);
            default: return bus_c.i_gpio_state;
        endcase
    endfunction

    function automatic logic in_en(int k);
        case (k)
            0:       return bus_a.i_enable;
            1:       return bus_b.i_enable;
            default: return bus_c.i_enable;
        endcase
    endfunction

    function automatic logic [3:0] act_pwm(int k);
        case (k)
            0:       return bus_a.o_pwm;
            1:       return bus_b.o_pwm;
            default: return bus_c.o_pwm;
        endcase
    endfunction

    function automatic logic act_ps(int k);
        case (k)
            0:       return bus_a.o_period_start;
            1:       return bus_b.o_period_start;
            default: return bus_c.o_period_start;
        endcase
    endfunction

    function automatic int field(logic [31:0] g, int ch, int k);
        return int'((g >> (ch * DW_M[k])) & 32'(MAX_M[k]));
    endfunction

    // n counts enabled edges since the run began; the step index within the
    // period and the period boundary follow from plain division.
    task automatic model_step();
        for (int k = 0; k < 3; k++) begin
            int          len;
            int          c;
            logic [31:0] g;
            len = P_M[k] * MAX_M[k];
            g   = in_gpio(k);
            if (rst) begin
                n_m[k] = 0;
                for (int ch = 0; ch < 4; ch++) duty_m[k][ch] = 0;
                exp_pwm[k] = '0;
                exp_ps[k]  = 1'b0;
            end else if (!in_en(k)) begin
                n_m[k] = 0;
                for (int ch = 0; ch < 4; ch++) duty_m[k][ch] = field(g, ch, k);
                exp_pwm[k] = '0;
                exp_ps[k]  = 1'b0;
            end else begin
                c = (n_m[k] / P_M[k]) % MAX_M[k];
                for (int ch = 0; ch < 4; ch++) exp_pwm[k][ch] = (c < duty_m[k][ch]);
                exp_ps[k] = ((n_m[k] % len) == len - 1);
                if (exp_ps[k])
                    for (int ch = 0; ch < 4; ch++) duty_m[k][ch] = field(g, ch, k);
                n_m[k] = n_m[k] + 1;
            end
        end
    endtask

    always @(posedge clk or posedge rst) model_step();

    // ---------------- scoreboard ----------------
    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("cyc_pwm%0d", k), 32'(act_pwm(k)), 32'(exp_pwm[k]));
            chk($sformatf("cyc_ps%0d", k),  32'(act_ps(k)),  32'(exp_ps[k]));
        end
    end

    // ---------------- driver tasks ----------------
    int hi [4];
    int first_hi [4];
    int last_hi [4];
    int ps_n;
    int ps_first;
    int ps_last;

    task automatic tick_n(int n);
        repeat (n) @(negedge clk);
    endtask

    // Observe one window of len cycles; optionally rewrite bus_a's word at sample chg_at.
    task automatic win(int k, int len, int chg_at, logic [15:0] chg_val);
        logic [3:0] p;
        for (int ch = 0; ch < 4; ch++) begin
            hi[ch] = 0; first_hi[ch] = -1; last_hi[ch] = -1;
        end
        ps_n = 0; ps_first = -1; ps_last = -1;
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            p = act_pwm(k);
            for (int ch = 0; ch < 4; ch++) begin
                if (p[ch]) begin
                    hi[ch]++;
                    if (first_hi[ch] < 0) first_hi[ch] = i;
                    last_hi[ch] = i;
                end
            end
            if (act_ps(k)) begin
                ps_n++;
                if (ps_first < 0) ps_first = i;
                ps_last = i;
            end
            if (k == 0 && i == chg_at) bus_a.i_gpio_state = chg_val;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bus_a.i_enable = 1'b0; bus_a.i_gpio_state = '0;
        bus_b.i_enable = 1'b0; bus_b.i_gpio_state = '0;
        bus_c.i_enable = 1'b0; bus_c.i_gpio_state = '0;
        tick_n(3);
        chk("reset_pwm_a", 32'(bus_a.o_pwm), 0);
        chk("reset_ps_a",  32'(bus_a.o_period_start), 0);
        rst = 1'b0;

        // duties 0,5,15,8 at prescale 1
        bus_a.i_gpio_state = 16'h8F50;
        tick_n(2);
        bus_a.i_enable = 1'b1;
        for (int w = 0; w < 3; w++) begin
            win(0, 15, -1, 16'h0);
            chk("t1_hi0", hi[0], 0);
            chk("t1_hi1", hi[1], 5);
            chk("t1_hi2", hi[2], 15);
            chk("t1_hi3", hi[3], 8);
            chk("t1_ps_n", ps_n, 1);
            chk("t1_ps_pos", ps_first, 14);
        end

        // duty change mid-period is deferred to the next period
        bus_a.i_enable = 1'b0;
        bus_a.i_gpio_state = 16'h0004;
        tick_n(2);
        bus_a.i_enable = 1'b1;
        win(0, 15, 5, 16'h000C);
        chk("t3_hi_old", hi[0], 4);
        chk("t3_ps_pos", ps_first, 14);
        win(0, 15, -1, 16'h0);
        chk("t3_hi_new", hi[0], 12);

        // enable drop mid-period, then a fresh restart
        bus_a.i_enable = 1'b0;
        bus_a.i_gpio_state = 16'h0F00;
        tick_n(2);
        bus_a.i_enable = 1'b1;
        tick_n(9);
        chk("t5_running", 32'(bus_a.o_pwm), 32'h4);
        bus_a.i_enable = 1'b0;
        tick_n(1);
        chk("t5_stopped", 32'(bus_a.o_pwm), 0);
        bus_a.i_gpio_state = 16'h0700;
        tick_n(2);
        bus_a.i_enable = 1'b1;
        win(0, 15, -1, 16'h0);
        chk("t5_hi2", hi[2], 7);
        chk("t5_hi0", hi[0], 0);
        chk("t5_ps_pos", ps_first, 14);

        // asynchronous reset between edges
        bus_a.i_enable = 1'b0;
        bus_a.i_gpio_state = 16'hFFFF;
        tick_n(2);
        bus_a.i_enable = 1'b1;
        tick_n(5);
        chk("t4_pre", 32'(bus_a.o_pwm), 32'hF);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("t4_async_pwm", 32'(bus_a.o_pwm), 0);
        chk("t4_async_ps",  32'(bus_a.o_period_start), 0);
        @(negedge clk);
        rst = 1'b0;
        win(0, 15, -1, 16'h0);
        chk("t4_low0", hi[0], 0);
        chk("t4_low3", hi[3], 0);
        chk("t4_ps_pos", ps_first, 14);
        win(0, 15, -1, 16'h0);
        chk("t4_high0", hi[0], 15);
        chk("t4_high3", hi[3], 15);

        // prescale 3, duty 5 on channel 1
        bus_b.i_gpio_state = 16'h0050;
        tick_n(2);
        bus_b.i_enable = 1'b1;
        for (int w = 0; w < 2; w++) begin
            win(1, 45, -1, 16'h0);
            chk("t2_hi1", hi[1], 15);
            chk("t2_first", first_hi[1], 0);
            chk("t2_last", last_hi[1], 14);
            chk("t2_hi0", hi[0], 0);
            chk("t2_ps_n", ps_n, 1);
            chk("t2_ps_pos", ps_first, 44);
        end

        // 8-bit duties: 255, 0, 128, 1 over 600 cycles
        bus_c.i_gpio_state = 32'h018000FF;
        tick_n(2);
        bus_c.i_enable = 1'b1;
        win(2, 600, -1, 16'h0);
        chk("t6_full", hi[0], 600);
        chk("t6_zero", hi[1], 0);
        chk("t6_half", hi[2], 346);
        chk("t6_one",  hi[3], 3);
        chk("t6_ps_n", ps_n, 2);
        chk("t6_ps_first", ps_first, 254);
        chk("t6_ps_last", ps_last, 509);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
